// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: shared constants for the stall-side hazard scoreboard.
//   REG_ZERO  - hardwired-zero register index
//   LAT_W     - width of the per-register remaining-latency counter
//   LAT_*     - issue latencies of the main instruction classes
//               (bubbles needed before the result is forwardable)
// Helper src_hazard() evaluates one source operand against the busy flags.
package hazard_pkg;

    localparam int unsigned LAT_W = 3;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [LAT_W-1:0] LAT_ALU  = LAT_W'(0);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_MUL  = LAT_W'(4);
    localparam logic [LAT_W-1:0] LAT_DIV  = LAT_W'(7);

    // One source operand is hazardous when it is read, is not r0, and its
    // producer has not yet reached a forwardable stage.
    function automatic logic src_hazard(input logic       used,
                                        input logic [4:0] idx,
                                        input logic       pending);
        return used && (idx != REG_ZERO) && pending;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_reg_countdown.sv
// reg_countdown: remaining-latency counter for one architectural register.
// Loads a new latency when an accepted writer targets the register (the
// newest writer always wins), otherwise counts down to zero and holds there.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset, clears the count
//   load     - accepted issue targets this register
//   load_val - latency of the issuing instruction
//   nz       - count is nonzero (result not yet forwardable)
module reg_countdown #(
    parameter int unsigned LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic             nz
);

    logic [LAT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

    assign nz = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stall-side partner of the EX/MEM forwarding unit.
// Tracks in-flight writers whose results are not yet forwardable (load-use,
// multi-cycle multiply/divide) and holds the ID-stage instruction, freezing
// PC and IF/ID and bubbling ID/EX, until all its sources are available.
// Optional feature macro: HAZARD_PERF_EN adds a saturating 32-bit stall
// cycle counter on stall_cnt_o.
// Ports:
//   clk_i, rst_i           - clock (rising edge), async active-high reset
//   ID_rs_i/ID_rt_i        - source register fields of the ID instruction
//   ID_rs_used_i/_rt_used_i- the ID instruction actually reads that source
//   issue_valid_i          - ID instruction advances into EX this cycle
//   issue_wb_i/issue_rd_i  - issuing instruction writes register issue_rd_i
//   issue_lat_i            - bubbles before its result is forwardable
//   stall_o                - hazard present, ID instruction must hold
//   PC_write_o, IF_ID_write_o - update enables (= !stall_o)
//   ID_EX_flush_o          - zero ID/EX control bits (= stall_o)
//   busy_o                 - any register still has a pending writer
//   stall_cnt_o            - (HAZARD_PERF_EN only) stalled-cycle count
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NREG  = 32,
    parameter int unsigned LAT_W = hazard_pkg::LAT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_rs_i,
    input  logic [4:0]       ID_rt_i,
    input  logic             ID_rs_used_i,
    input  logic             ID_rt_used_i,
    input  logic             issue_valid_i,
    input  logic             issue_wb_i,
    input  logic [4:0]       issue_rd_i,
    input  logic [LAT_W-1:0] issue_lat_i,
    output logic             stall_o,
    output logic             PC_write_o,
    output logic             IF_ID_write_o,
    output logic             ID_EX_flush_o,
`ifdef HAZARD_PERF_EN
    output logic [31:0]      stall_cnt_o,
`endif
    output logic             busy_o
);

    // Pending flags padded to the full 5-bit index space so the read muxes
    // never index out of range when NREG < 32.
    logic [31:0] pending;
    logic        accept;
    logic        rs_hit;
    logic        rt_hit;

    assign pending[0] = 1'b0;

    genvar r;
    generate
        for (r = 1; r < 32; r++) begin : g_reg
            if (r < NREG) begin : g_cnt
                logic load;
                assign load = accept && (issue_rd_i == 5'(r));

                reg_countdown #(
                    .LAT_W (LAT_W)
                ) u_cnt (
                    .clk      (clk_i),
                    .rst      (rst_i),
                    .load     (load),
                    .load_val (issue_lat_i),
                    .nz       (pending[r])
                );
            end else begin : g_none
                assign pending[r] = 1'b0;
            end
        end
    endgenerate

    // rs==rt simply evaluates the same flag twice; the OR keeps it one hazard.
    always_comb begin
        rs_hit  = src_hazard(ID_rs_used_i, ID_rs_i, pending[ID_rs_i]);
        rt_hit  = src_hazard(ID_rt_used_i, ID_rt_i, pending[ID_rt_i]);
        stall_o = rs_hit || rt_hit;
    end

    // A stalled cycle injects a bubble, so its issue must not be recorded.
    assign accept = issue_valid_i && !stall_o && issue_wb_i &&
                    (issue_rd_i != REG_ZERO);

    assign PC_write_o    = !stall_o;
    assign IF_ID_write_o = !stall_o;
    assign ID_EX_flush_o = stall_o;
    assign busy_o        = |pending;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [4:0]       ID_rs_i = '0;
    logic [4:0]       ID_rt_i = '0;
    logic             ID_rs_used_i = 1'b0;
    logic             ID_rt_used_i = 1'b0;
    logic             issue_valid_i = 1'b0;
    logic             issue_wb_i = 1'b0;
    logic [4:0]       issue_rd_i = '0;
    logic [LAT_W-1:0] issue_lat_i = '0;
    logic             stall_o;
    logic             PC_write_o;
    logic             IF_ID_write_o;
    logic             ID_EX_flush_o;
    logic             busy_o;
`ifdef HAZARD_PERF_EN
    logic [31:0]      stall_cnt_o;
`endif

    hazard_scoreboard #(
        .NREG  (32),
        .LAT_W (LAT_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ID_rs_i       (ID_rs_i),
        .ID_rt_i       (ID_rt_i),
        .ID_rs_used_i  (ID_rs_used_i),
        .ID_rt_used_i  (ID_rt_used_i),
        .issue_valid_i (issue_valid_i),
        .issue_wb_i    (issue_wb_i),
        .issue_rd_i    (issue_rd_i),
        .issue_lat_i   (issue_lat_i),
        .stall_o       (stall_o),
        .PC_write_o    (PC_write_o),
        .IF_ID_write_o (IF_ID_write_o),
        .ID_EX_flush_o (ID_EX_flush_o),
`ifdef HAZARD_PERF_EN
        .stall_cnt_o   (stall_cnt_o),
`endif
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        logic        stall;
        logic        busy;
        logic [31:0] perf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: each register remembers the cycle index from which
    // its value is forwardable; a source stalls while that cycle is ahead.
    longint ready_at[32];
    longint cyc = 0;
    longint perf_model = 0;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) ready_at[i] = 0;
        perf_model = 0;
    endtask

    function automatic logic src_wait(input logic used, input logic [4:0] idx);
        return used && (idx != 5'd0) && (ready_at[idx] > cyc);
    endfunction

    function automatic logic any_busy();
        for (int i = 1; i < 32; i++)
            if (ready_at[i] > cyc) return 1'b1;
        return 1'b0;
    endfunction

    // One pipeline cycle. want >= 0 pins the expected stall to a hand-derived
    // constant; want < 0 takes it from the reference model.
    task automatic step(input string tag, input logic r,
                        input logic [4:0] rs, input logic rsu,
                        input logic [4:0] rt, input logic rtu,
                        input logic iv, input logic wb,
                        input logic [4:0] rd, input logic [LAT_W-1:0] lat,
                        input int want);
        exp_t e;
        logic st;
        @(posedge clk_i);
        #1;
        cyc++;
        rst_i = r; ID_rs_i = rs; ID_rs_used_i = rsu; ID_rt_i = rt; ID_rt_used_i = rtu;
        issue_valid_i = iv; issue_wb_i = wb; issue_rd_i = rd; issue_lat_i = lat;
        e.tag = tag;
        if (r) begin
            model_clear();
            e.stall = 1'b0;
            e.busy  = 1'b0;
            e.perf  = 32'd0;
        end else begin
            st = src_wait(rsu, rs) || src_wait(rt, rtu ? rt : 5'd0) ;
            st = src_wait(rsu, rs) || src_wait(rtu, rt);
            e.stall = (want >= 0) ? want[0] : st;
            e.busy  = any_busy();
            e.perf  = perf_model[31:0];
            if (st) perf_model++;
            if (iv && !st && wb && rd != 5'd0)
                ready_at[rd] = cyc + 1 + longint'(lat);
        end
        q.push_back(e);
    endtask

    task automatic idle(input string tag, input int want);
        step(tag, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, '0, want);
    endtask

    task automatic cmp(input string name, input string tag,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s/%s actual=%0h required=%0h", tag, name, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs, pop and compare.
    always @(negedge clk_i) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp("stall",  e.tag, 32'(stall_o),       32'(e.stall));
            cmp("pcwr",   e.tag, 32'(PC_write_o),    32'(!e.stall));
            cmp("ifidwr", e.tag, 32'(IF_ID_write_o), 32'(!e.stall));
            cmp("flush",  e.tag, 32'(ID_EX_flush_o), 32'(e.stall));
            cmp("busy",   e.tag, 32'(busy_o),        32'(e.busy));
`ifdef HAZARD_PERF_EN
            cmp("perf",   e.tag, stall_cnt_o,        e.perf);
`endif
        end
    end

    initial begin
        model_clear();
        // Reset state
        step("rst0", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, '0, 0);
        step("rst1", 1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 5'd0, '0, 0);
        idle("post_rst", 0);

        // Load-use: exactly one stall
        step("lw",    1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, LAT_LOAD, 0);
        step("lu_s1", 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, '0, 1);
        step("lu_go", 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, '0, 0);

        // ALU back-to-back: forwarding covers it
        step("alu",   1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, LAT_ALU, 0);
        step("alu_d", 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 5'd0, '0, 0);

        // Multiply: four stalls for an immediate dependent (rs==rt too)
        step("mul",   1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd10, LAT_MUL, 0);
        for (int i = 0; i < 4; i++)
            step("mul_s", 1'b0, 5'd10, 1'b1, 5'd10, 1'b1, 1'b1, 1'b0, 5'd0, '0, 1);
        step("mul_go", 1'b0, 5'd10, 1'b1, 5'd10, 1'b1, 1'b1, 1'b0, 5'd0, '0, 0);

        // Independent consumer while a multiply is in flight
        step("mul2", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd10, LAT_MUL, 0);
        for (int i = 0; i < 4; i++)
            step("indep", 1'b0, 5'd11, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, '0, 0);
        idle("mul2_done", 0);

        // Zero register never tracked
        step("r0w", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, LAT_MUL, 0);
        step("r0r", 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, '0, 0);

        // WAW: newest writer wins
        step("waw1",  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd12, LAT_MUL, 0);
        step("waw2",  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd12, LAT_LOAD, 0);
        step("waw_s", 1'b0, 5'd12, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, '0, 1);
        step("waw_go",1'b0, 5'd12, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, '0, 0);

        // Long latency with a later dependent: N-k stalls
        step("div",   1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd13, LAT_DIV, 0);
        idle("div_k1", 0);
        idle("div_k2", 0);
        for (int i = 0; i < 5; i++)
            step("div_s", 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1, 1'b0, 5'd0, '0, 1);
        step("div_go", 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1, 1'b0, 5'd0, '0, 0);

        // Reset mid-stall clears all counters
        step("m5",    1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 3'd3, 0);
        step("m5_s",  1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, '0, 1);
        step("m5_rst",1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, '0, 0);
        step("m5_rel",1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, '0, 0);

        // Randomized traffic on a small register window to force collisions
        for (int n = 0; n < 3000; n++) begin
            logic [LAT_W-1:0] lat;
            case ($urandom_range(0, 4))
                0: lat = LAT_ALU;
                1: lat = LAT_LOAD;
                2: lat = LAT_MUL;
                3: lat = LAT_DIV;
                default: lat = LAT_W'($urandom_range(0, 7));
            endcase
            step("rnd", ($urandom_range(0, 199) == 0),
                 5'($urandom_range(0, 7)), 1'($urandom),
                 5'($urandom_range(0, 7)), 1'($urandom),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 8),
                 5'($urandom_range(0, 7)), lat, -1);
        end

        idle("tail", -1);
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
